// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: data side has priority over instruction fetch.
// Optional instruction anti-starvation: define ARB_FAIRNESS_EN.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        grant_d
);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        grant_d_q, grant_d_d;

    logic d_req, starved, grant_i, grant_dside, i_done, d_done;

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    assign starved = iREN && (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts back-to-back data grants only while a fetch is actually waiting.
    always_comb begin
        starve_d = starve_q;
        if (!iREN || grant_i)
            starve_d = '0;
        else if (grant_dside)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign starved = 1'b0;

    // The limit only matters when fairness is built in.
    if (STARVE_LIMIT < 0) begin : g_limit_unused
    end
`endif

    assign d_req       = dREN | dWEN;
    assign grant_dside = (state_q == IDLE) && d_req && !starved;
    assign grant_i     = (state_q == IDLE) && iREN && (!d_req || starved);
    assign i_done      = (state_q == I_ACC) && ram_ready;
    assign d_done      = (state_q == D_ACC) && ram_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        store_d   = store_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        grant_d_d = grant_d_q;
        case (state_q)
            IDLE: begin
                // Write wins when both data strobes are up.
                if (grant_dside) begin
                    state_d   = D_ACC;
                    addr_d    = daddr;
                    store_d   = dstore;
                    ren_d     = !dWEN;
                    wen_d     = dWEN;
                    grant_d_d = 1'b1;
                end else if (grant_i) begin
                    state_d   = I_ACC;
                    addr_d    = iaddr;
                    store_d   = '0;
                    ren_d     = 1'b1;
                    wen_d     = 1'b0;
                    grant_d_d = 1'b0;
                end
            end
            I_ACC, D_ACC: begin
                if (ram_ready) begin
                    state_d = IDLE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            store_q   <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            grant_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            grant_d_q <= grant_d_d;
        end
    end

    // A withdrawn request still finishes its access; the wait flags simply
    // follow the live request, so nothing is reported to a departed requester.
    assign iwait    = iREN && !i_done;
    assign dwait    = d_req && !d_done;
    assign iload    = i_done ? ramload : '0;
    assign dload    = d_done ? ramload : '0;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign grant_d  = grant_d_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_memory_arbiter;

    localparam int LIMIT = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, grant_d;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .grant_d(grant_d)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // {iwait, dwait, ramREN, ramWEN, grant_d, ramaddr, ramstore, iload, dload}
    typedef logic [132:0] obs_t;

    typedef struct {
        logic        iren, dren, dwen, rdy;
        logic [31:0] ia, da, ds, rl;
        obs_t        exp;
    } vec_t;

    function automatic obs_t mk_obs(logic iw, logic dw, logic re, logic we, logic gd,
                                    logic [31:0] ra, logic [31:0] rs,
                                    logic [31:0] il, logic [31:0] dl);
        return {iw, dw, re, we, gd, ra, rs, il, dl};
    endfunction

    function automatic vec_t mk(logic ir, logic dr, logic dw, logic rd,
                                logic [31:0] ia, logic [31:0] da,
                                logic [31:0] ds, logic [31:0] rl, obs_t e);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.rdy = rd;
        v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.exp = e;
        return v;
    endfunction

    task automatic apply(logic ir, logic dr, logic dw, logic rd,
                         logic [31:0] ia, logic [31:0] da,
                         logic [31:0] ds, logic [31:0] rl);
        iREN = ir; dREN = dr; dWEN = dw; ram_ready = rd;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    endtask

    task automatic step(logic ir, logic dr, logic dw, logic rd,
                        logic [31:0] ia, logic [31:0] da,
                        logic [31:0] ds, logic [31:0] rl);
        @(posedge CLK);
        #1 apply(ir, dr, dw, rd, ia, da, ds, rl);
        @(negedge CLK);
    endtask

    task automatic check(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic obs_t observed();
        return mk_obs(iwait, dwait, ramREN, ramWEN, grant_d, ramaddr, ramstore, iload, dload);
    endfunction

    vec_t vecs[15];

    // Reference model: who owns the RAM and what was captured at grant time.
    int          m_owner;   // 0 none, 1 instruction, 2 data
    logic [31:0] m_addr, m_store;
    logic        m_write, m_last_d;
    int          m_streak;

    task automatic model_reset();
        m_owner = 0; m_addr = '0; m_store = '0; m_write = 1'b0;
        m_last_d = 1'b0; m_streak = 0;
    endtask

    task automatic model_edge();
        int granted;
        granted = 0;
        if (m_owner != 0) begin
            if (ram_ready) m_owner = 0;
        end else if ((dREN || dWEN) && !(FAIR && iREN && m_streak == LIMIT)) begin
            granted = 2;
            m_owner = 2; m_addr = daddr; m_store = dstore; m_write = dWEN; m_last_d = 1'b1;
        end else if (iREN) begin
            granted = 1;
            m_owner = 1; m_addr = iaddr; m_store = '0; m_write = 1'b0; m_last_d = 1'b0;
        end
        if (!iREN || granted == 1) m_streak = 0;
        else if (granted == 2) m_streak++;
    endtask

    function automatic obs_t model_out();
        logic ifin, dfin;
        ifin = (m_owner == 1) && ram_ready;
        dfin = (m_owner == 2) && ram_ready;
        return mk_obs(iREN && !ifin, (dREN || dWEN) && !dfin,
                      (m_owner == 1) || (m_owner == 2 && !m_write),
                      (m_owner == 2) && m_write, m_last_d, m_addr, m_store,
                      ifin ? ramload : 32'h0, dfin ? ramload : 32'h0);
    endfunction

    initial begin
        int ngrants;
        bit exp_d;

        // Lone fetch, simultaneous request, write precedence.
        vecs[0]  = mk(1,0,0,0, 32'h40,0,0,0,             mk_obs(1,0,0,0,0, 32'h0,0,0,0));
        vecs[1]  = mk(1,0,0,0, 32'h40,0,0,0,             mk_obs(1,0,1,0,0, 32'h40,0,0,0));
        vecs[2]  = mk(1,0,0,0, 32'h40,0,0,0,             mk_obs(1,0,1,0,0, 32'h40,0,0,0));
        vecs[3]  = mk(1,0,0,1, 32'h40,0,0,32'hDEADBEEF,  mk_obs(0,0,1,0,0, 32'h40,0,32'hDEADBEEF,0));
        vecs[4]  = mk(0,0,0,0, 0,0,0,0,                  mk_obs(0,0,0,0,0, 32'h40,0,0,0));
        vecs[5]  = mk(1,1,0,0, 32'h44,32'h100,0,0,       mk_obs(1,1,0,0,0, 32'h40,0,0,0));
        vecs[6]  = mk(1,1,0,0, 32'h44,32'h100,0,0,       mk_obs(1,1,1,0,1, 32'h100,0,0,0));
        vecs[7]  = mk(1,1,0,1, 32'h44,32'h100,0,32'hA5A5,mk_obs(1,0,1,0,1, 32'h100,0,0,32'hA5A5));
        vecs[8]  = mk(1,0,0,0, 32'h44,0,0,0,             mk_obs(1,0,0,0,1, 32'h100,0,0,0));
        vecs[9]  = mk(1,0,0,1, 32'h44,0,0,32'h77,        mk_obs(0,0,1,0,0, 32'h44,0,32'h77,0));
        vecs[10] = mk(0,0,0,0, 0,0,0,0,                  mk_obs(0,0,0,0,0, 32'h44,0,0,0));
        vecs[11] = mk(0,1,1,0, 0,32'h8,32'h1234,0,       mk_obs(0,1,0,0,0, 32'h44,0,0,0));
        vecs[12] = mk(0,1,1,0, 0,32'h8,32'h1234,0,       mk_obs(0,1,0,1,1, 32'h8,32'h1234,0,0));
        vecs[13] = mk(0,1,1,1, 0,32'h8,32'h1234,32'h55,  mk_obs(0,0,0,1,1, 32'h8,32'h1234,0,32'h55));
        vecs[14] = mk(0,0,0,0, 0,0,0,0,                  mk_obs(0,0,0,0,1, 32'h8,32'h1234,0,0));

        nRST = 1'b0;
        apply(0,0,0,0, 0,0,0,0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_state", observed(), mk_obs(0,0,0,0,0, 0,0,0,0));
        nRST = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rdy,
                 vecs[i].ia, vecs[i].da, vecs[i].ds, vecs[i].rl);
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // Starvation: fetch held against a continuous data stream.
        ngrants = 0;
        for (int c = 0; c < 30 && ngrants < 6; c++) begin
            step(1,1,0,1, 32'h60,32'h400,0,32'h5);
            if (ramREN) begin
                exp_d = !(FAIR && ngrants == LIMIT);
                check($sformatf("starve_grant%0d", ngrants), obs_t'(grant_d), obs_t'(exp_d));
                ngrants++;
            end
        end
        checks++;
        if (ngrants < 6) begin
            errors++;
            $display("FAIL starve_timeout: got %0d grants required 6", ngrants);
        end
        step(0,0,0,0, 0,0,0,0);

        // Reset in the middle of a data read.
        step(0,1,0,0, 0,32'h200,0,0);
        step(0,1,0,0, 0,32'h200,0,0);
        check("rst_pre", observed(), mk_obs(0,1,1,0,1, 32'h200,0,0,0));
        #1 nRST = 1'b0;
        #1 check("rst_async", observed(), mk_obs(0,1,0,0,0, 0,0,0,0));
        ram_ready = 1'b1; ramload = 32'h99;
        @(negedge CLK);
        nRST = 1'b1;
        #1 check("rst_release", observed(), mk_obs(0,1,0,0,0, 0,0,0,0));
        @(negedge CLK);
        check("rst_regrant", observed(), mk_obs(0,0,1,0,1, 32'h200,0,0,32'h99));
        step(0,0,0,0, 0,0,0,0);
        check("rst_idle", observed(), mk_obs(0,0,0,0,1, 32'h200,0,0,0));

        // Data request withdrawn mid-access while a fetch arrives.
        step(0,1,0,0, 0,32'h300,0,0);
        check("wd_grant", observed(), mk_obs(0,1,0,0,1, 32'h200,0,0,0));
        step(1,0,0,0, 32'h50,0,0,0);
        check("wd_drop", observed(), mk_obs(1,0,1,0,1, 32'h300,0,0,0));
        step(1,0,0,1, 32'h50,0,0,32'h1111);
        check("wd_finish", observed(), mk_obs(1,0,1,0,1, 32'h300,0,0,32'h1111));
        step(1,0,0,0, 32'h50,0,0,0);
        check("wd_idle", observed(), mk_obs(1,0,0,0,1, 32'h300,0,0,0));
        step(1,0,0,1, 32'h50,0,0,32'h2222);
        check("wd_fetch", observed(), mk_obs(0,0,1,0,0, 32'h50,0,32'h2222,0));
        step(0,0,0,0, 0,0,0,0);
        check("wd_end", observed(), mk_obs(0,0,0,0,0, 32'h50,0,0,0));

        // Randomized run against the reference model.
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        model_reset();
        nRST = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge CLK);
            model_edge();
            #1 apply($urandom_range(0,3) != 0, $urandom_range(0,1) == 1,
                     $urandom_range(0,3) == 0, $urandom_range(0,1) == 1,
                     $urandom, $urandom, $urandom, $urandom);
            @(negedge CLK);
            check($sformatf("rand%0d", c), observed(), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
